// File: rtl/spi_sram_pkg.sv
// Shared constants, FSM encoding and frame builder for the SPI SRAM master.
package spi_sram_pkg;

    localparam logic [7:0]  INSTR_READ  = 8'h03;
    localparam logic [7:0]  INSTR_WRITE = 8'h02;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned FRAME_W     = 8 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        return rw ? {INSTR_WRITE, addr, wdata} : {INSTR_READ, addr, {DATA_W{1'b0}}};
    endfunction

endpackage

// File: rtl/spi_sram_if.sv
// Request/response handshake plus SPI pins of the SRAM master.
interface spi_sram_if;
    import spi_sram_pkg::*;

    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              csb;
    logic              sck;
    logic              si;
    logic              so;

    modport master (
        input  start, rw, addr, wdata, so,
        output rdata, busy, done, csb, sck, si
    );

    modport slave (
        output start, rw, addr, wdata, so,
        input  rdata, busy, done, csb, sck, si
    );

endinterface

// File: rtl/spi_clk_gen.sv
// Divider producing a registered mode-0 sck with single-cycle rise/fall strobes.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en,
    input  logic sck_en,
    output logic sck,
    output logic rise,
    output logic fall,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    assign tick = cnt_en && (cnt == LAST);
    assign rise = tick && sck_en && !sck;
    assign fall = tick && sck_en && sck;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            sck <= 1'b0;
        end else begin
            if (!cnt_en || tick)
                cnt <= '0;
            else
                cnt <= cnt + 8'd1;
            if (!sck_en)
                sck <= 1'b0;
            else if (tick)
                sck <= ~sck;
        end
    end

endmodule

// File: rtl/spi_sram_master.sv
// Single-byte SPI SRAM read/write master: 32-bit frame {instr, addr, data}, MSB first.
module spi_sram_master
    import spi_sram_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    spi_sram_if.master bus
);

    state_t state, state_next;

    logic               load, finish, last_fall, sample;
    logic               sck, sck_rise, sck_fall, tick;
    logic [4:0]         bit_cnt;
    logic [FRAME_W-1:0] frame, shreg;
    logic [DATA_W-1:0]  rx, rdata_q;
    logic               is_read, csb_q, si_q, busy_q, done_q;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk    (clk),
        .rst    (rst),
        .cnt_en (state != ST_IDLE),
        .sck_en (state == ST_SHIFT),
        .sck    (sck),
        .rise   (sck_rise),
        .fall   (sck_fall),
        .tick   (tick)
    );

    assign frame = build_frame(bus.rw, bus.addr, bus.wdata);

    // bit_cnt advances on rises, so at the fall of bit k it holds (k+1) mod 32
    assign last_fall = sck_fall && (bit_cnt == 5'd0);
    assign sample    = is_read && sck_fall && (bit_cnt >= 5'd25 || bit_cnt == 5'd0);

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_SHIFT;
                    load       = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (last_fall)
                    state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (tick) begin
                    state_next = ST_IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg   <= '0;
            rx      <= '0;
            rdata_q <= '0;
            bit_cnt <= '0;
            is_read <= 1'b0;
            csb_q   <= 1'b1;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                shreg   <= frame;
                si_q    <= frame[FRAME_W-1];
                csb_q   <= 1'b0;
                busy_q  <= 1'b1;
                is_read <= ~bus.rw;
                bit_cnt <= '0;
                rx      <= '0;
            end else if (state == ST_SHIFT) begin
                if (sck_rise)
                    bit_cnt <= bit_cnt + 5'd1;
                if (sck_fall) begin
                    shreg <= {shreg[FRAME_W-2:0], 1'b0};
                    si_q  <= shreg[FRAME_W-2];
                end
                if (sample)
                    rx <= {rx[DATA_W-2:0], bus.so};
            end else if (finish) begin
                csb_q  <= 1'b1;
                si_q   <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                if (is_read)
                    rdata_q <= rx;
            end
        end
    end

    assign bus.sck   = sck;
    assign bus.csb   = csb_q;
    assign bus.si    = si_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_sram_master.sv
// Scoreboard bench: SPI SRAM responder on the CLK_DIV=2 instance, bit capture on the CLK_DIV=1 instance.
module tb_spi_sram_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_sram_if b0();
    spi_sram_if b1();

    spi_sram_master #(.CLK_DIV(2)) dut  (.clk(clk), .rst(rst), .bus(b0));
    spi_sram_master #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct { logic [31:0] frame; logic [7:0] rdata; } exp_t;
    typedef struct { logic [31:0] word; int unsigned nbits; } got_t;

    exp_t exp_q[$];
    got_t got_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0]  mem [0:65535];
    logic        sck_p = 1'b0, csb_p = 1'b1;
    logic [31:0] sh = '0;
    int unsigned nb = 0;
    logic [7:0]  rbyte = '0, rinst = '0;

    // SRAM responder: samples si on sck rise, presents read data on so after the rise
    always @(negedge clk) begin
        if (b0.csb === 1'b1) begin
            if (!csb_p) got_q.push_back('{word: sh, nbits: nb});
            nb = 0; sh = '0; b0.so = 1'b0;
        end else if (b0.sck && !sck_p) begin
            sh = {sh[30:0], b0.si};
            nb++;
            if (nb == 24) begin rinst = sh[23:16]; rbyte = mem[sh[15:0]]; end
            if (nb >= 25 && nb <= 32 && rinst == 8'h03) b0.so = rbyte[3'(32 - nb)];
            if (nb == 32 && sh[31:24] == 8'h02) mem[sh[23:8]] = sh[7:0];
        end
        sck_p = b0.sck;
        csb_p = b0.csb;
    end

    task automatic run_frame(input logic w, input logic [15:0] a, input logic [7:0] d,
                             input logic [7:0] exp_rd, input int inj_cyc,
                             output int done_cyc, output int ndone, output int csb_low,
                             output logic [3:0] snap1, output logic [1:0] sck23, output logic [7:0] rd);
        exp_q.push_back('{frame: w ? {8'h02, a, d} : {8'h03, a, 8'h00}, rdata: exp_rd});
        @(negedge clk);
        b0.start = 1'b1; b0.rw = w; b0.addr = a; b0.wdata = d;
        done_cyc = -1; ndone = 0; csb_low = 0; snap1 = '0; sck23 = '0; rd = '0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            b0.start = (c == inj_cyc);
            if (c == 1) snap1 = {b0.csb, b0.busy, b0.sck, b0.si};
            if (c == 2) sck23[1] = b0.sck;
            if (c == 3) sck23[0] = b0.sck;
            if (!b0.csb) csb_low++;
            if (b0.done) begin
                ndone++;
                if (done_cyc < 0) begin done_cyc = c; rd = b0.rdata; end
            end
            if (done_cyc > 0 && c >= done_cyc + 3) break;
        end
        b0.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; b0.start = 1'b1; b1.start = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({b0.csb, b0.sck, b0.si, b0.busy, b0.done} !== 5'b10000 || b0.rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state got csb/sck/si/busy/done=%b rdata=%h want 10000 00",
                     {b0.csb, b0.sck, b0.si, b0.busy, b0.done}, b0.rdata);
        end
        rst = 1'b1; b0.start = 1'b0; b1.start = 1'b0;
        @(negedge clk);
        vectors++;
        if (b0.busy !== 1'b0 || b0.csb !== 1'b1 || b1.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_in_reset got busy=%b csb=%b busy1=%b want 0 1 0", b0.busy, b0.csb, b1.busy);
        end
    endtask

    task automatic test_write();
        int dc, nd, cl; logic [3:0] s1; logic [1:0] s23; logic [7:0] rd; exp_t e; got_t g;
        run_frame(1'b1, 16'h1234, 8'hA5, 8'h00, 0, dc, nd, cl, s1, s23, rd);
        vectors++;
        if (dc !== 131 || nd !== 1) begin
            miscompares++; $display("FAIL write_done got cycle=%0d count=%0d want 131 1", dc, nd);
        end
        vectors++;
        if (cl !== 130) begin miscompares++; $display("FAIL write_csb_low got %0d want 130", cl); end
        vectors++;
        if (s1 !== 4'b0100) begin miscompares++; $display("FAIL write_first_cycle got csb/busy/sck/si=%b want 0100", s1); end
        vectors++;
        if (s23 !== 2'b01) begin miscompares++; $display("FAIL write_first_rise got sck c2/c3=%b want 01", s23); end
        vectors++;
        if (exp_q.size() == 0 || got_q.size() == 0) begin
            miscompares++; $display("FAIL write_frame got no frame want one");
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g.word !== e.frame || g.nbits != 32) begin
                miscompares++; $display("FAIL write_frame got %h/%0d bits want %h/32", g.word, g.nbits, e.frame);
            end
            vectors++;
            if (rd !== e.rdata) begin miscompares++; $display("FAIL write_rdata_kept got %h want %h", rd, e.rdata); end
        end
    endtask

    task automatic test_read(input logic [15:0] a, input logic [7:0] want, input string tag);
        int dc, nd, cl; logic [3:0] s1; logic [1:0] s23; logic [7:0] rd; exp_t e; got_t g;
        run_frame(1'b0, a, 8'hFF, want, 0, dc, nd, cl, s1, s23, rd);
        vectors++;
        if (dc !== 131 || nd !== 1) begin
            miscompares++; $display("FAIL %s_done got cycle=%0d count=%0d want 131 1", tag, dc, nd);
        end
        vectors++;
        if (exp_q.size() == 0 || got_q.size() == 0) begin
            miscompares++; $display("FAIL %s_frame got no frame want one", tag);
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g.word !== e.frame || g.nbits != 32) begin
                miscompares++; $display("FAIL %s_frame got %h/%0d bits want %h/32", tag, g.word, g.nbits, e.frame);
            end
            vectors++;
            if (rd !== e.rdata) begin miscompares++; $display("FAIL %s_rdata got %h want %h", tag, rd, e.rdata); end
        end
    endtask

    task automatic test_write_read();
        int dc, nd, cl; logic [3:0] s1; logic [1:0] s23; logic [7:0] rd; exp_t e; got_t g;
        run_frame(1'b1, 16'h1FFF, 8'h5A, 8'h3C, 0, dc, nd, cl, s1, s23, rd);
        vectors++;
        if (exp_q.size() == 0 || got_q.size() == 0) begin
            miscompares++; $display("FAIL wr_frame got no frame want one");
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g.word !== e.frame || rd !== e.rdata || dc !== 131) begin
                miscompares++;
                $display("FAIL wr_frame got %h rdata=%h done=%0d want %h %h 131", g.word, rd, dc, e.frame, e.rdata);
            end
        end
        test_read(16'h1FFF, 8'h5A, "rd_back");
    endtask

    task automatic test_start_while_busy();
        int dc, nd, cl; logic [3:0] s1; logic [1:0] s23; logic [7:0] rd; exp_t e; got_t g;
        run_frame(1'b1, 16'h0042, 8'hC3, 8'h5A, 43, dc, nd, cl, s1, s23, rd);
        vectors++;
        if (nd !== 1 || dc !== 131) begin
            miscompares++; $display("FAIL busy_start_done got count=%0d cycle=%0d want 1 131", nd, dc);
        end
        vectors++;
        if (b0.busy !== 1'b0 || b0.csb !== 1'b1) begin
            miscompares++; $display("FAIL busy_start_queued got busy=%b csb=%b want 0 1", b0.busy, b0.csb);
        end
        vectors++;
        if (exp_q.size() == 0 || got_q.size() != 1) begin
            miscompares++; $display("FAIL busy_start_frames got %0d frames want 1", got_q.size());
        end else begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g.word !== e.frame || rd !== e.rdata) begin
                miscompares++; $display("FAIL busy_start_frame got %h rdata=%h want %h %h", g.word, rd, e.frame, e.rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dc; logic [7:0] rd1, rd2; exp_t e; got_t g;
        exp_q.push_back('{frame: {8'h03, 16'h0010, 8'h00}, rdata: 8'h3C});
        @(negedge clk);
        b0.start = 1'b1; b0.rw = 1'b0; b0.addr = 16'h0010;
        @(negedge clk);
        b0.start = 1'b0;
        dc = -1; rd1 = '0; rd2 = '0;
        for (int c = 2; c <= 200; c++) begin
            @(negedge clk);
            if (b0.done) begin dc = c; rd1 = b0.rdata; break; end
        end
        vectors++;
        if (dc !== 131 || rd1 !== 8'h3C) begin
            miscompares++; $display("FAIL b2b_first got cycle=%0d rdata=%h want 131 3c", dc, rd1);
        end
        exp_q.push_back('{frame: {8'h03, 16'h1FFF, 8'h00}, rdata: 8'h5A});
        b0.start = 1'b1; b0.addr = 16'h1FFF;
        @(negedge clk);
        b0.start = 1'b0;
        vectors++;
        if (b0.csb !== 1'b0 || b0.busy !== 1'b1 || b0.done !== 1'b0) begin
            miscompares++; $display("FAIL b2b_accept got csb=%b busy=%b done=%b want 0 1 0", b0.csb, b0.busy, b0.done);
        end
        dc = -1;
        for (int c = 2; c <= 200; c++) begin
            @(negedge clk);
            if (b0.done) begin dc = c; rd2 = b0.rdata; break; end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (dc !== 131 || rd2 !== 8'h5A) begin
            miscompares++; $display("FAIL b2b_second got cycle=%0d rdata=%h want 131 5a", dc, rd2);
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (exp_q.size() == 0 || got_q.size() == 0) begin
                miscompares++; $display("FAIL b2b_frame%0d got no frame want one", i);
            end else begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                if (g.word !== e.frame || g.nbits != 32) begin
                    miscompares++; $display("FAIL b2b_frame%0d got %h/%0d want %h/32", i, g.word, g.nbits, e.frame);
                end
            end
        end
    endtask

    task automatic test_abort();
        int nd; got_t g;
        @(negedge clk);
        b0.start = 1'b1; b0.rw = 1'b1; b0.addr = 16'h0BAD; b0.wdata = 8'h77;
        for (int c = 1; c <= 83; c++) begin
            @(negedge clk);
            b0.start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({b0.csb, b0.sck, b0.si, b0.busy, b0.done} !== 5'b10000 || b0.rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_state got csb/sck/si/busy/done=%b rdata=%h want 10000 00",
                     {b0.csb, b0.sck, b0.si, b0.busy, b0.done}, b0.rdata);
        end
        rst = 1'b1;
        nd = 0;
        repeat (150) begin
            @(negedge clk);
            if (b0.done) nd++;
        end
        vectors++;
        if (nd !== 0) begin miscompares++; $display("FAIL abort_no_done got %0d pulses want 0", nd); end
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++; $display("FAIL abort_partial got %0d frames want 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            if (g.nbits != 21) begin miscompares++; $display("FAIL abort_partial got %0d bits want 21", g.nbits); end
        end
        test_read(16'h0010, 8'h3C, "after_abort");
    endtask

    task automatic test_clkdiv1();
        int dc, cl, rises; logic [31:0] word; logic p; logic [1:0] s23; exp_t e;
        exp_q.push_back('{frame: {8'h02, 16'hBEEF, 8'h3D}, rdata: 8'h00});
        @(negedge clk);
        b1.start = 1'b1; b1.rw = 1'b1; b1.addr = 16'hBEEF; b1.wdata = 8'h3D;
        dc = -1; cl = 0; rises = 0; word = '0; p = 1'b0; s23 = '0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            b1.start = 1'b0;
            if (c == 2) s23[1] = b1.sck;
            if (c == 3) s23[0] = b1.sck;
            if (b1.sck && !p) begin word = {word[30:0], b1.si}; rises++; end
            p = b1.sck;
            if (!b1.csb) cl++;
            if (b1.done) begin dc = c; break; end
        end
        e = exp_q.pop_front();
        vectors++;
        if (dc !== 66 || cl !== 65) begin
            miscompares++; $display("FAIL div1_timing got done=%0d csb_low=%0d want 66 65", dc, cl);
        end
        vectors++;
        if (s23 !== 2'b10) begin miscompares++; $display("FAIL div1_sck_period got c2/c3=%b want 10", s23); end
        vectors++;
        if (word !== e.frame || rises !== 32 || b1.rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL div1_frame got %h/%0d rdata=%h want %h/32 %h", word, rises, b1.rdata, e.frame, e.rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h3C;
        b0.start = 1'b0; b0.rw = 1'b0; b0.addr = '0; b0.wdata = '0;
        b1.start = 1'b0; b1.rw = 1'b0; b1.addr = '0; b1.wdata = '0; b1.so = 1'b0;
        test_reset();
        test_write();
        test_read(16'h0010, 8'h3C, "read");
        test_write_read();
        test_start_while_busy();
        test_back_to_back();
        test_abort();
        test_clkdiv1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
